// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states,
// load/store size encodings and the IO address window.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // addr[17:16] value that marks the IO space (stores there obey io_buffer_full)
  localparam logic [1:0] IO_SPACE = 2'b11;

  // Number of bytes moved for a given size code; the unused code behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_extend.sv
// Sign/zero extension of an assembled little-endian load value.
module mem_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] ext
);

  // Extend from the top bit of the loaded quantity when sign is set.
  always_comb begin
    case (size)
      SIZE_BYTE: ext = {{24{sign & raw[7]}}, raw[7:0]};
      SIZE_HALF: ext = {{16{sign & raw[15]}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction-fetch port and a
// load/store port onto a RAM with one cycle of read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  input  logic        ls_req,
  input  logic        ls_write,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] data_reg;
  logic [1:0]  size_reg;
  logic        sign_reg;
  logic        io_reg;
  logic        squash_reg;

  logic [2:0]  nbytes;
  logic [1:0]  byte_idx;
  logic [1:0]  wbyte_idx;
  logic [31:0] merged;
  logic [31:0] load_ext;
  logic [31:0] addr_inc;
  logic [7:0]  wbyte_next;
  logic        store_stall;
  logic        accept_stall;
  logic        last_read;
  logic        more_read;
  logic        last_store;

  // In a read, cnt_reg counts edges since acceptance minus one; the byte
  // arriving on mem_din at the current edge is byte cnt_reg-1.
  assign nbytes       = size_bytes(size_reg);
  assign byte_idx     = cnt_reg[1:0] - 2'd1;
  assign wbyte_idx    = cnt_reg[1:0] + 2'd1;
  assign addr_inc     = addr_reg + {29'd0, cnt_reg} + 32'd1;
  assign wbyte_next   = wdata_reg[{wbyte_idx, 3'b000} +: 8];
  assign store_stall  = io_reg & io_buffer_full;
  assign accept_stall = (ls_addr[17:16] == IO_SPACE) & io_buffer_full;
  assign last_read    = (cnt_reg == nbytes);
  assign more_read    = ((cnt_reg + 3'd1) < nbytes);
  assign last_store   = ((cnt_reg + 3'd1) == nbytes);

  // Drop the incoming byte into its little-endian lane so the final byte is
  // already included in the value registered at the valid edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = ((cnt_reg != 3'd0) && (byte_idx == 2'(gi)))
                                 ? mem_din : data_reg[8*gi +: 8];
    end
  endgenerate

  mem_extend u_extend (
    .raw  (merged),
    .size (size_reg),
    .sign (sign_reg),
    .ext  (load_ext)
  );

  // Main FSM: arbitration, byte sequencing, RAM port and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 3'd0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      data_reg   <= 32'd0;
      size_reg   <= SIZE_BYTE;
      sign_reg   <= 1'b0;
      io_reg     <= 1'b0;
      squash_reg <= 1'b0;
      if_valid   <= 1'b0;
      if_inst    <= 32'd0;
      ls_valid   <= 1'b0;
      ls_rdata   <= 32'd0;
      mem_a      <= 32'd0;
      mem_dout   <= 8'd0;
      mem_wr     <= 1'b0;
    end else if (rdy) begin
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          mem_wr     <= 1'b0;
          mem_a      <= 32'd0;
          mem_dout   <= 8'd0;
          cnt_reg    <= 3'd0;
          data_reg   <= 32'd0;
          squash_reg <= 1'b0;
          // Load/store wins over fetch; a rollback edge accepts nothing.
          if (!rollback && ls_req) begin
            addr_reg  <= ls_addr;
            size_reg  <= ls_size;
            sign_reg  <= ls_signed;
            wdata_reg <= ls_wdata;
            io_reg    <= (ls_addr[17:16] == IO_SPACE);
            mem_a     <= ls_addr;
            if (ls_write) begin
              state_reg <= STORE;
              mem_wr    <= !accept_stall;
              mem_dout  <= ls_wdata[7:0];
            end else begin
              state_reg <= LOAD;
            end
          end else if (!rollback && if_req) begin
            addr_reg  <= if_addr;
            size_reg  <= SIZE_WORD;
            sign_reg  <= 1'b0;
            io_reg    <= 1'b0;
            mem_a     <= if_addr;
            state_reg <= FETCH;
          end
        end

        FETCH, LOAD: begin
          if (rollback) begin
            // Flushed read: abandon quietly.
            state_reg <= IDLE;
            mem_a     <= 32'd0;
            cnt_reg   <= 3'd0;
          end else begin
            data_reg <= merged;
            mem_a    <= more_read ? addr_inc : 32'd0;
            cnt_reg  <= cnt_reg + 3'd1;
            if (last_read) begin
              state_reg <= IDLE;
              cnt_reg   <= 3'd0;
              if (state_reg == FETCH) begin
                if_valid <= 1'b1;
                if_inst  <= merged;
              end else begin
                ls_valid <= 1'b1;
                ls_rdata <= load_ext;
              end
            end
          end
        end

        STORE: begin
          // A store already on the bus always finishes; rollback only hides its valid.
          if (rollback) begin
            squash_reg <= 1'b1;
          end
          if (mem_wr) begin
            if (last_store) begin
              state_reg <= IDLE;
              mem_wr    <= 1'b0;
              mem_a     <= 32'd0;
              mem_dout  <= 8'd0;
              cnt_reg   <= 3'd0;
              ls_valid  <= !(squash_reg | rollback);
            end else begin
              cnt_reg  <= cnt_reg + 3'd1;
              mem_a    <= addr_inc;
              mem_dout <= wbyte_next;
              mem_wr   <= !store_stall;
            end
          end else begin
            // Byte held for a full IO buffer; address and data stay put.
            mem_wr <= !store_stall;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
